// File: rtl/shift_pair_scheduler.sv
// shift_pair_scheduler
// Round-robin arbiter for two requesters sharing one shift_in_8bit datapath.
// Each transfer: one IDLE cycle to arbitrate and capture the word pair,
// two LOAD cycles with Load asserted, SHIFT_LEN SHIFT cycles counting down,
// then one DONE cycle pulsing the owner's Ack.
module shift_pair_scheduler #(
  parameter int SHIFT_LEN = 8
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [7:0] Data0_A,
  input  logic [7:0] Data0_B,
  input  logic [7:0] Data1_A,
  input  logic [7:0] Data1_B,
  output logic [7:0] Data_A,
  output logic [7:0] Data_B,
  output logic       Load,
  output logic       Ack0,
  output logic       Ack1,
  output logic [1:0] Grant,
  output logic       Busy,
  output logic [3:0] Bit_Cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Five bits so that SHIFT_LEN = 16 still counts the full number of cycles.
  localparam logic [4:0] SHIFT_LEN_W = 5'(SHIFT_LEN);

  state_t     state_reg, state_next;
  logic       load_cnt_reg;     // high during the second LOAD cycle
  logic [4:0] cnt_reg;          // remaining shift cycles
  logic [1:0] grant_reg;        // one-hot owner, zero when idle
  logic       last_owner_reg;   // 0 = Req0 served last, 1 = Req1 served last
  logic [7:0] data_a_reg, data_b_reg;
  logic       any_req;
  logic       pick1;            // arbitration result: 1 selects Req1

  assign any_req = Req0 | Req1;
  // Req1 wins when it is alone, or on a tie when Req0 was the last one served.
  assign pick1   = Req1 & (~Req0 | ~last_owner_reg);

  // State register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (any_req) state_next = LOAD;
      LOAD:    if (load_cnt_reg) state_next = SHIFT;
      SHIFT:   if (cnt_reg == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping: owner, captured word pair, LOAD and SHIFT counters.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      load_cnt_reg   <= 1'b0;
      cnt_reg        <= 5'd0;
      grant_reg      <= 2'b00;
      last_owner_reg <= 1'b1;
      data_a_reg     <= 8'h00;
      data_b_reg     <= 8'h00;
    end else begin
      load_cnt_reg <= (state_reg == LOAD) && !load_cnt_reg;
      unique case (state_reg)
        IDLE: begin
          cnt_reg <= 5'd0;
          if (any_req) begin
            grant_reg  <= pick1 ? 2'b10 : 2'b01;
            data_a_reg <= pick1 ? Data1_A : Data0_A;
            data_b_reg <= pick1 ? Data1_B : Data0_B;
          end
        end
        LOAD: begin
          if (load_cnt_reg) cnt_reg <= SHIFT_LEN_W;
        end
        SHIFT: begin
          cnt_reg <= cnt_reg - 5'd1;
        end
        DONE: begin
          last_owner_reg <= grant_reg[1];
          grant_reg      <= 2'b00;
          cnt_reg        <= 5'd0;
        end
        default: cnt_reg <= 5'd0;
      endcase
    end
  end

  // Outputs decoded from the current state; Bit_Cnt saturates at 15 when
  // SHIFT_LEN is 16 because the port is only four bits wide.
  always_comb begin
    Load    = 1'b0;
    Ack0    = 1'b0;
    Ack1    = 1'b0;
    Busy    = (state_reg != IDLE);
    Bit_Cnt = 4'd0;
    unique case (state_reg)
      LOAD:    Load = 1'b1;
      SHIFT:   Bit_Cnt = (cnt_reg > 5'd15) ? 4'd15 : cnt_reg[3:0];
      DONE: begin
        Ack0 = grant_reg[0];
        Ack1 = grant_reg[1];
      end
      default: ;
    endcase
  end

  assign Grant  = grant_reg;
  assign Data_A = data_a_reg;
  assign Data_B = data_b_reg;

endmodule

// File: tb/tb_shift_pair_scheduler.sv
// Scoreboard bench for shift_pair_scheduler: stimulus pushes expected
// transfers, a negedge monitor reconstructs each transfer and compares on Ack.
module tb_shift_pair_scheduler;

  localparam int SL = 8;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [7:0] Data0_A = 8'h00, Data0_B = 8'h00, Data1_A = 8'h00, Data1_B = 8'h00;
  logic [7:0] Data_A, Data_B;
  logic       Load, Ack0, Ack1, Busy;
  logic [1:0] Grant;
  logic [3:0] Bit_Cnt;

  shift_pair_scheduler #(.SHIFT_LEN(SL)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Req0(Req0), .Req1(Req1),
    .Data0_A(Data0_A), .Data0_B(Data0_B), .Data1_A(Data1_A), .Data1_B(Data1_B),
    .Data_A(Data_A), .Data_B(Data_B), .Load(Load), .Ack0(Ack0), .Ack1(Ack1),
    .Grant(Grant), .Busy(Busy), .Bit_Cnt(Bit_Cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         who;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   inv_err  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int who, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.who = who; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Monitor state
  bit         in_xfer = 0, expect_idle = 0;
  logic [7:0] cap_a, cap_b;
  logic [1:0] cap_g;
  int         load_cyc, shift_cyc, busy_cyc, bitcnt_err, stable_err;

  always @(negedge CLK) begin
    if (!Reset_n) begin
      in_xfer     = 0;
      expect_idle = 0;
    end else begin
      if ((Ack0 && Ack1) || Grant == 2'b11 || (Load && Bit_Cnt != 4'd0)) inv_err++;
      if (expect_idle) begin
        chk("idle_gap_busy", int'(Busy), 0);
        chk("idle_gap_load", int'(Load), 0);
        expect_idle = 0;
      end
      if (Busy && !in_xfer) begin
        in_xfer = 1;
        cap_a = Data_A; cap_b = Data_B; cap_g = Grant;
        load_cyc = 0; shift_cyc = 0; busy_cyc = 0; bitcnt_err = 0; stable_err = 0;
      end
      if (in_xfer) begin
        busy_cyc++;
        if (Load) load_cyc++;
        if (Bit_Cnt != 4'd0) begin
          if (int'(Bit_Cnt) != SL - shift_cyc) bitcnt_err++;
          shift_cyc++;
        end
        if (Data_A != cap_a || Data_B != cap_b) stable_err++;
      end
      if (Ack0 || Ack1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          int   who;
          e   = exp_q.pop_front();
          who = Ack1 ? 1 : 0;
          $display("xfer: req%0d a=%02h b=%02h grant=%b load=%0d shift=%0d busy=%0d",
                   who, cap_a, cap_b, cap_g, load_cyc, shift_cyc, busy_cyc);
          chk("ack_owner", who, e.who);
          chk("data_a", int'(cap_a), int'(e.a));
          chk("data_b", int'(cap_b), int'(e.b));
          chk("grant", int'(cap_g), (e.who == 0) ? 1 : 2);
          chk("load_cycles", load_cyc, 2);
          chk("shift_cycles", shift_cyc, SL);
          chk("busy_cycles", busy_cyc, SL + 3);
          chk("bit_cnt_seq_errors", bitcnt_err, 0);
          chk("data_stable_errors", stable_err, 0);
        end
        in_xfer     = 0;
        expect_idle = 1;
      end
    end
  end

  // Wait for the Ack of requester 'who'; latency counts the IDLE cycle too.
  task automatic wait_ack(input int who, input bit check_lat, input bit drop);
    bit hit = 0;
    for (int k = 1; k <= 60 && !hit; k++) begin
      @(negedge CLK);
      if ((who == 0 && Ack0) || (who == 1 && Ack1)) begin
        hit = 1;
        if (check_lat) chk("latency", k + 1, SL + 4);
        if (drop) begin
          if (who == 0) Req0 = 1'b0;
          else          Req1 = 1'b0;
        end
      end
    end
    chk(who == 0 ? "ack0_seen" : "ack1_seen", int'(hit), 1);
  endtask

  // sel 0: SHIFT reached, 1: Bit_Cnt == 4, 2: Load high
  task automatic wait_sel(input int sel, input string name);
    bit hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge CLK);
      case (sel)
        0:       hit = (Bit_Cnt != 4'd0);
        1:       hit = (Bit_Cnt == 4'd4);
        default: hit = Load;
      endcase
    end
    chk(name, int'(hit), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_a"}, int'(Data_A), 0);
    chk({tag, "_data_b"}, int'(Data_B), 0);
    chk({tag, "_load"}, int'(Load), 0);
    chk({tag, "_ack0"}, int'(Ack0), 0);
    chk({tag, "_ack1"}, int'(Ack1), 0);
    chk({tag, "_grant"}, int'(Grant), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_bit_cnt"}, int'(Bit_Cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_zero("reset");
    Reset_n = 1'b1;
    @(negedge CLK);

    // Single request, latency 12
    Data0_A = 8'd5; Data0_B = 8'd15;
    push(0, 8'd5, 8'd15);
    Req0 = 1'b1;
    wait_ack(0, 1'b1, 1'b1);
    @(negedge CLK);

    // Tie after reset: Req0 first, then Req1
    do_reset();
    Data1_A = 8'hA5; Data1_B = 8'h3C;
    push(0, 8'd5, 8'd15);
    push(1, 8'hA5, 8'h3C);
    Req0 = 1'b1; Req1 = 1'b1;
    wait_ack(0, 1'b1, 1'b1);
    wait_ack(1, 1'b0, 1'b1);
    @(negedge CLK);

    // Fairness: Req0 held, Req1 arrives during SHIFT
    Data0_A = 8'h11; Data0_B = 8'h22; Data1_A = 8'h33; Data1_B = 8'h44;
    push(0, 8'h11, 8'h22);
    Req0 = 1'b1;
    wait_sel(0, "fair_shift_reached");
    push(1, 8'h33, 8'h44);
    Req1 = 1'b1;
    wait_ack(0, 1'b0, 1'b0);
    wait_ack(1, 1'b0, 1'b1);
    push(0, 8'h11, 8'h22);
    wait_ack(0, 1'b0, 1'b1);
    @(negedge CLK);

    // Data stability: unselected and selected inputs change mid-SHIFT
    Data0_A = 8'd5; Data0_B = 8'd15;
    push(0, 8'd5, 8'd15);
    Req0 = 1'b1;
    wait_sel(0, "stab_shift_reached");
    Data0_A = 8'hFF; Data1_A = 8'h77; Data1_B = 8'h88;
    wait_ack(0, 1'b0, 1'b1);
    @(negedge CLK);

    // Reset mid-SHIFT at Bit_Cnt = 4, then full restart
    Data0_A = 8'h5A; Data0_B = 8'hC3;
    Req0 = 1'b1;
    wait_sel(1, "bitcnt4_reached");
    Reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge CLK);
    push(0, 8'h5A, 8'hC3);
    Reset_n = 1'b1;
    wait_ack(0, 1'b1, 1'b1);
    @(negedge CLK);

    // Req1 dropped during LOAD still completes
    Data1_A = 8'h0F; Data1_B = 8'hF0;
    push(1, 8'h0F, 8'hF0);
    Req1 = 1'b1;
    wait_sel(2, "drop_load_reached");
    Req1 = 1'b0;
    wait_ack(1, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    chk("final_busy", int'(Busy), 0);

    chk("invariant_errors", inv_err, 0);
    chk("queue_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
